// File: rtl/inst_stream_packer_pkg.sv
// Shared types and helpers for packing a mixed 16/32-bit instruction stream
// into aligned 32-bit memory words.
package inst_stream_packer_pkg;

    typedef logic [15:0] halfword_t;

    typedef enum logic {
        HW_LO = 1'b0,
        HW_HI = 1'b1
    } hw_sel_e;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } pack_state_e;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;

    // RV32C: any encoding whose low two bits are not 2'b11 is a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] lsb);
        return lsb != 2'b11;
    endfunction

endpackage

// File: rtl/inst_stream_packer_pack_out_reg.sv
// One-entry valid/ready output register for packed words; a clear drops the
// held word without presenting it.
module pack_out_reg #(
    parameter logic [31:0] RESET_ADDR = 32'h200
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        clr_i,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  be_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] word_o,
    output logic [31:0] addr_o,
    output logic [3:0]  be_o
);

    logic        valid_q;
    logic [31:0] word_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;

    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            addr_q  <= RESET_ADDR;
            be_q    <= '0;
        end else begin
            if (clr_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (load_i && !clr_i) begin
                word_q <= word_i;
                addr_q <= addr_i;
                be_q   <= be_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign word_o  = word_q;
    assign addr_o  = addr_q;
    assign be_o    = be_q;

endmodule

// File: rtl/inst_stream_packer.sv
// Packs a stream of mixed 16/32-bit instructions into aligned 32-bit words with
// byte enables for the instruction memory write port.
module inst_stream_packer
    import inst_stream_packer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h200
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] start_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic [3:0]  out_be,
    output logic        flush_done,
    output logic        idle
);

    localparam logic [31:0] RESET_WADDR = {RESET_PC[31:2], 2'b00};

    pack_state_e state_q, state_d;
    hw_sel_e     hp_q, hp_d;
    logic        hold_vld_q, hold_vld_d;
    halfword_t   hold_q, hold_d;
    logic [31:0] wptr_q, wptr_d;
    logic        flush_done_q, flush_done_d;

    logic        emit;
    logic [31:0] emit_word;
    logic [3:0]  emit_be;
    logic        slot_free;
    logic        accept;
    logic        inst16;
    halfword_t   lo_half;
    logic        unused_addr_bit;

    assign unused_addr_bit = start_addr[0];

    assign slot_free = ~out_valid | out_ready;
    assign in_ready  = (state_q == RUN) & slot_free & ~start;
    assign accept    = in_valid & in_ready;
    assign inst16    = is_compressed(in_inst[1:0]);
    // After a misaligned start the low half of the first word was never written.
    assign lo_half   = hold_vld_q ? hold_q : 16'h0000;

    always_comb begin
        state_d      = state_q;
        hp_d         = hp_q;
        hold_vld_d   = hold_vld_q;
        hold_d       = hold_q;
        wptr_d       = wptr_q;
        flush_done_d = 1'b0;
        emit         = 1'b0;
        emit_word    = in_inst;
        emit_be      = BE_FULL;

        if (start) begin
            state_d    = RUN;
            hold_vld_d = 1'b0;
            hp_d       = hw_sel_e'(start_addr[1]);
            wptr_d     = {start_addr[31:2], 2'b00};
        end else if (state_q == RUN) begin
            if (accept) begin
                if (hp_q == HW_LO) begin
                    if (inst16) begin
                        hold_d     = in_inst[15:0];
                        hold_vld_d = 1'b1;
                        hp_d       = HW_HI;
                    end else begin
                        emit   = 1'b1;
                        wptr_d = wptr_q + 32'd4;
                    end
                end else begin
                    emit      = 1'b1;
                    emit_word = {in_inst[15:0], lo_half};
                    emit_be   = hold_vld_q ? BE_FULL : BE_HI;
                    wptr_d    = wptr_q + 32'd4;
                    if (inst16) begin
                        hp_d       = HW_LO;
                        hold_vld_d = 1'b0;
                    end else begin
                        hold_d     = in_inst[31:16];
                        hold_vld_d = 1'b1;
                    end
                end
            end
            // Flush looks at the hold after this cycle's packing.
            if (flush) begin
                if (hold_vld_d) begin
                    state_d = DRAIN;
                end else begin
                    flush_done_d = 1'b1;
                end
            end
        end else if (slot_free) begin
            emit         = 1'b1;
            emit_word    = {16'h0000, hold_q};
            emit_be      = BE_LO;
            wptr_d       = wptr_q + 32'd4;
            hp_d         = HW_LO;
            hold_vld_d   = 1'b0;
            state_d      = RUN;
            flush_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= RUN;
            hp_q         <= hw_sel_e'(RESET_PC[1]);
            hold_vld_q   <= 1'b0;
            wptr_q       <= RESET_WADDR;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hp_q         <= hp_d;
            hold_vld_q   <= hold_vld_d;
            wptr_q       <= wptr_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    pack_out_reg #(
        .RESET_ADDR (RESET_WADDR)
    ) u_out (
        .clk_i   (clk),
        .n_rst_i (n_rst),
        .clr_i   (start),
        .load_i  (emit),
        .word_i  (emit_word),
        .addr_i  (wptr_q),
        .be_i    (emit_be),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .word_o  (out_word),
        .addr_o  (out_addr),
        .be_o    (out_be)
    );

    assign flush_done = flush_done_q;
    assign idle       = ~hold_vld_q & ~out_valid & (state_q == RUN);

endmodule

// File: tb/tb_inst_stream_packer.sv
// Scoreboard bench for inst_stream_packer: a halfword-granular memory model
// predicts every packed word; a negedge monitor compares what the DUT presents.
module tb_inst_stream_packer;

    logic        clk = 1'b0;
    logic        n_rst, start, in_valid, flush, out_ready;
    logic [31:0] start_addr, in_inst;
    logic        in_ready, out_valid, flush_done, idle;
    logic [31:0] out_word, out_addr;
    logic [3:0]  out_be;

    always #5 clk = ~clk;

    inst_stream_packer #(.RESET_PC(32'h200)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .start_addr (start_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_addr   (out_addr),
        .out_be     (out_be),
        .flush_done (flush_done),
        .idle       (idle)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] a;
        logic [3:0]  be;
    } exp_t;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          exp_fd = 0;

    // Reference model: byte address of the next free halfword and an optional
    // not-yet-written-out lower halfword of the current word.
    logic [31:0] m_pc = 32'h200;
    logic        m_has_lo = 1'b0;
    logic [15:0] m_lo = 16'h0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic m_reset(input logic [31:0] pc);
        q.delete();
        exp_fd   = 0;
        m_pc     = pc & 32'hFFFF_FFFE;
        m_has_lo = 1'b0;
    endtask

    task automatic m_half(input logic [15:0] h);
        exp_t e;
        if (m_pc[1]) begin
            e.w  = {h, (m_has_lo ? m_lo : 16'h0)};
            e.a  = {m_pc[31:2], 2'b00};
            e.be = m_has_lo ? 4'hF : 4'hC;
            q.push_back(e);
            m_has_lo = 1'b0;
        end else begin
            m_lo     = h;
            m_has_lo = 1'b1;
        end
        m_pc = m_pc + 32'd2;
    endtask

    task automatic m_flush();
        exp_t e;
        if (m_has_lo) begin
            e.w  = {16'h0, m_lo};
            e.a  = {m_pc[31:2], 2'b00};
            e.be = 4'h3;
            q.push_back(e);
            m_has_lo = 1'b0;
            m_pc = m_pc + 32'd2;
        end
        exp_fd++;
    endtask

    // Monitor: inputs change only just after posedge, so at negedge they are
    // exactly what the next posedge will sample.
    logic        prev_stall = 1'b0;
    logic [68:0] prev_out = '0;

    always @(negedge clk) begin
        exp_t e;
        if (prev_stall) begin
            check("stall_stable", 64'({out_valid, out_be, out_word}), 64'(prev_out[36:0]));
            check("stall_addr", 64'(out_addr), 64'(prev_out[68:37]));
        end
        prev_stall = n_rst & out_valid & ~out_ready & ~start;
        prev_out   = {out_addr, out_valid, out_be, out_word};

        if (n_rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_word: got %0h @%0h be %0h, required none", out_word, out_addr, out_be);
            end else begin
                e = q.pop_front();
                check("word_addr", {out_word, out_addr}, {e.w, e.a});
                check("be", 64'(out_be), 64'(e.be));
            end
        end
        if (n_rst && flush_done) begin
            check("flush_done_expected", 64'(exp_fd > 0), 64'(1));
            if (exp_fd > 0) exp_fd--;
        end

        if (!n_rst) begin
            m_reset(32'h200);
        end else if (start) begin
            m_reset(start_addr);
        end else begin
            if (in_valid && in_ready) begin
                m_half(in_inst[15:0]);
                if (in_inst[1:0] == 2'b11) m_half(in_inst[31:16]);
            end
            if (flush) m_flush();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst);
        int n = 0;
        tick();
        in_valid = 1'b1;
        in_inst  = inst;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] a);
        tick();
        start      = 1'b1;
        start_addr = a;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_fd();
        int n = 0;
        @(negedge clk);
        while (!flush_done && n < 100) begin
            n++;
            tick();
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        check("flush_done_wait", 64'(flush_done), 64'(1));
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] v;
        v = $urandom;
        if ($urandom_range(0, 1) == 1) v[1:0] = 2'b11;
        return v;
    endfunction

    initial begin
        n_rst = 1'b0; start = 1'b0; start_addr = '0; in_valid = 1'b0;
        in_inst = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_word", 64'(out_word), 64'(0));
        check("rst_out_addr", 64'(out_addr), 64'h200);
        check("rst_out_be", 64'(out_be), 64'(0));
        check("rst_flush_done", 64'(flush_done), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_idle", 64'(idle), 64'(1));
        tick();
        n_rst = 1'b1;

        // T1: aligned 32-bit instruction, one cycle latency
        send(32'h0050_0093);
        @(negedge clk);
        check("t1_valid", 64'(out_valid), 64'(1));
        check("t1_word", 64'(out_word), 64'h0050_0093);
        check("t1_addr", 64'(out_addr), 64'h200);
        check("t1_be", 64'(out_be), 64'hF);

        // T2: two compressed halves form one word
        do_start(32'h200);
        send(32'h0000_4505);
        @(negedge clk);
        check("t2_no_out", 64'(out_valid), 64'(0));
        send(32'h0000_4585);
        @(negedge clk);
        check("t2_word", {out_word, out_addr}, {32'h4585_4505, 32'h200});
        check("t2_be", 64'(out_be), 64'hF);

        // T3: straddling 32-bit instruction, then flush the upper half
        do_start(32'h200);
        send(32'h0000_4505);
        send(32'h00A0_0113);
        @(negedge clk);
        check("t3_word", {out_word, out_addr}, {32'h0113_4505, 32'h200});
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        @(negedge clk);
        check("t3_drain_word", {out_word, out_addr}, {32'h0000_00A0, 32'h204});
        check("t3_drain_be", 64'({out_valid, out_be}), 64'h13);
        check("t3_flush_done", 64'(flush_done), 64'(1));

        // T4: misaligned start fills only the upper half; flush has nothing to drain
        do_start(32'h302);
        send(32'h0000_4505);
        @(negedge clk);
        check("t4_word", {out_word, out_addr}, {32'h4505_0000, 32'h300});
        check("t4_be", 64'(out_be), 64'hC);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t4_flush_done", 64'(flush_done), 64'(1));
        check("t4_idle", 64'(idle), 64'(1));

        // T5: output back-pressure with input pending
        do_start(32'h200);
        out_ready = 1'b0;
        send(32'h0050_0093);
        in_valid = 1'b1;
        in_inst  = 32'h00A0_0113;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_in_ready", 64'(in_ready), 64'(0));
            check("t5_hold", 64'({out_valid, out_word}), {31'h0, 1'b1, 32'h0050_0093});
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_resume", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t5_second", {out_word, out_addr}, {32'h00A0_0113, 32'h204});

        // T6: start aborts a stalled DRAIN
        do_start(32'h200);
        out_ready = 1'b0;
        send(32'h0000_4505);
        send(32'h00A0_0113);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("t6_busy", 64'(idle), 64'(0));
        tick();
        start = 1'b1;
        start_addr = 32'h400;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("t6_out_valid", 64'(out_valid), 64'(0));
        check("t6_idle", 64'(idle), 64'(1));

        // T7: reset mid-DRAIN
        out_ready = 1'b0;
        send(32'h0000_4505);
        send(32'h00A0_0113);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        @(negedge clk);
        check("t7_rst", 64'({out_valid, idle, out_addr}), {30'h0, 1'b0, 1'b1, 32'h200});
        tick();
        out_ready = 1'b1;

        // Randomized stream with flushes, restarts (incl. address wrap) and back-pressure
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            tick();
            start     = 1'b0;
            flush     = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 1) == 1);
            in_inst   = rand_inst();
            if (r < 2) begin
                start      = 1'b1;
                start_addr = (r == 0) ? (32'hFFFF_FFF8 + 32'($urandom_range(0, 7))) : $urandom;
            end else if (r < 6) begin
                flush = 1'b1;
                tick();
                flush    = 1'b0;
                in_valid = 1'b0;
                wait_fd();
            end
        end

        tick();
        start = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("end_queue_empty", 64'(q.size()), 64'(0));
        check("end_flush_done_owed", 64'(exp_fd), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
